// File: rtl/cdc_pulse_scheduler.sv
// rtl/cdc_pulse_scheduler.sv - round-robin scheduler sharing one pulse CDC channel among N event sources
//
// Ports:
//   clk           source-domain clock of the crossing channel
//   reset_i       synchronous active-high reset
//   enable_i      permits new grants (IDLE -> ISSUE) when high
//   req_i         per-requester single-cycle event pulses
//   holdoff_i     idle cycles inserted after each pulse, sampled in ISSUE
//   drop_clear_i  restarts the drop counter (that cycle's drops still count)
//   pulse_o       one-cycle pulse to the channel's src_pulse
//   sel_o         requester index of the current or most recent pulse
//   pending_o     latched events not yet served
//   busy_o        FSM is in ISSUE or HOLD
//   drop_count_o  saturating count of events lost to an already-pending bit
module cdc_pulse_scheduler #(
    parameter int pREQUESTERS = 4,
    parameter int pHOLD_WIDTH = 8,
    parameter int pDROP_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_i,
    input  logic                             enable_i,
    input  logic [pREQUESTERS-1:0]           req_i,
    input  logic [pHOLD_WIDTH-1:0]           holdoff_i,
    input  logic                             drop_clear_i,
    output logic                             pulse_o,
    output logic [$clog2(pREQUESTERS)-1:0]   sel_o,
    output logic [pREQUESTERS-1:0]           pending_o,
    output logic                             busy_o,
    output logic [pDROP_WIDTH-1:0]           drop_count_o
);

    localparam int SEL_W = $clog2(pREQUESTERS);
    localparam int CNT_W = $clog2(pREQUESTERS + 1);
    // One spare bit above the wider operand so overflow is visible before saturating.
    localparam int SUM_W = ((pDROP_WIDTH > CNT_W) ? pDROP_WIDTH : CNT_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_pulse;
    logic                     r_busy;
    logic [SEL_W-1:0]         r_sel;
    logic [SEL_W-1:0]         r_ptr;
    logic [pREQUESTERS-1:0]   r_pending;
    logic [pHOLD_WIDTH-1:0]   r_hold_cnt;
    logic [pDROP_WIDTH-1:0]   r_drop_count;

    logic                     w_grant_found;
    logic [SEL_W-1:0]         w_grant_idx;
    logic [SEL_W:0]           w_scan;
    logic                     w_take;
    logic [pREQUESTERS-1:0]   w_clear;
    logic [pREQUESTERS-1:0]   w_drop_vec;
    logic [CNT_W-1:0]         w_drop_num;
    logic [pDROP_WIDTH-1:0]   w_drop_base;
    logic [SUM_W-1:0]         w_sum;
    logic [pDROP_WIDTH-1:0]   w_drop_next;

    // Round-robin search starting one past the last granted index, wrapping at N.
    // The scan index carries one extra bit so ptr+i never overflows before the wrap.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int i = 1; i <= pREQUESTERS; i++) begin
            w_scan = {1'b0, r_ptr} + (SEL_W+1)'(i);
            if (w_scan >= (SEL_W+1)'(pREQUESTERS)) begin
                w_scan = w_scan - (SEL_W+1)'(pREQUESTERS);
            end
            if (!w_grant_found && r_pending[w_scan[SEL_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan[SEL_W-1:0];
            end
        end
    end

    assign w_take = (r_state == ST_IDLE) && enable_i && w_grant_found;

    always_comb begin
        w_clear = '0;
        if (w_take) begin
            w_clear[w_grant_idx] = 1'b1;
        end
    end

    // A request colliding with the bit being granted this cycle is not a drop:
    // the set overrides the clear, so the event survives as a fresh pending one.
    assign w_drop_vec = req_i & r_pending & ~w_clear;

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < pREQUESTERS; i++) begin
            w_drop_num = w_drop_num + CNT_W'(w_drop_vec[i]);
        end
    end

    assign w_drop_base = drop_clear_i ? '0 : r_drop_count;
    assign w_sum       = SUM_W'(w_drop_base) + SUM_W'(w_drop_num);
    assign w_drop_next = (|w_sum[SUM_W-1:pDROP_WIDTH]) ? {pDROP_WIDTH{1'b1}}
                                                        : w_sum[pDROP_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_pulse      <= 1'b0;
            r_busy       <= 1'b0;
            r_sel        <= '0;
            r_ptr        <= SEL_W'(pREQUESTERS - 1);
            r_pending    <= '0;
            r_hold_cnt   <= '0;
            r_drop_count <= '0;
        end else begin
            r_pending    <= (r_pending & ~w_clear) | req_i;
            r_drop_count <= w_drop_next;

            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state <= ST_ISSUE;
                        r_pulse <= 1'b1;
                        r_busy  <= 1'b1;
                        r_sel   <= w_grant_idx;
                        r_ptr   <= w_grant_idx;
                    end
                end

                ST_ISSUE: begin
                    r_pulse    <= 1'b0;
                    r_hold_cnt <= holdoff_i;
                    if (holdoff_i == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    r_hold_cnt <= r_hold_cnt - pHOLD_WIDTH'(1);
                    // Leaving on the count of one makes HOLD last exactly holdoff_i cycles.
                    if (r_hold_cnt == pHOLD_WIDTH'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o      = r_pulse;
    assign sel_o        = r_sel;
    assign pending_o    = r_pending;
    assign busy_o       = r_busy;
    assign drop_count_o = r_drop_count;

endmodule
